// File: rtl/multi_channel_counter_pkg.sv
// Shared constants for the multi-channel counter block: direction and mode
// encodings plus a helper that builds the all-ones limit for any width.
package multi_channel_counter_pkg;

  // Direction encoding on the per-channel dir input
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Limit behaviour selected by the SAT parameter
  localparam int unsigned MODE_WRAP = 32'd0;
  localparam int unsigned MODE_SAT  = 32'd1;

  // Default geometry of the shared counter resource
  localparam int unsigned DEFAULT_WIDTH  = 32'd8;
  localparam int unsigned DEFAULT_NUM_CH = 32'd3;

  // Widest counter the max_count helper can describe
  localparam int unsigned MAX_WIDTH = 32'd64;

  // All-ones value for a counter of the given width, right-aligned.
  // Callers cast the result down to their own width.
  function automatic logic [MAX_WIDTH-1:0] max_count(input int unsigned width);
    logic [MAX_WIDTH-1:0] ones_v;
    ones_v    = {MAX_WIDTH{1'b1}};
    max_count = ones_v >> (MAX_WIDTH - width);
  endfunction

endpackage

// File: rtl/multi_channel_counter_channel.sv
// One WIDTH-bit counter channel: enable, up/down, synchronous load and clear,
// wrap or saturate at the limits, a one-cycle terminal-count pulse and a
// sticky overflow flag. All outputs come straight from flops.
module counter_channel
  import multi_channel_counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned SAT   = MODE_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(max_count(WIDTH));
  localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tc_q;
  logic             tc_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             at_limit_s;
  logic [WIDTH-1:0] wrap_val_s;
  logic [WIDTH-1:0] step_val_s;

  // Detect a step that would cross a limit and precompute both candidate values
  always_comb begin
    at_limit_s = 1'b0;
    wrap_val_s = ZERO_VAL;
    step_val_s = count_q;
    if (dir == DIR_UP) begin
      at_limit_s = (count_q == MAX_VAL);
      wrap_val_s = ZERO_VAL;
      step_val_s = count_q + ONE_VAL;
    end else begin
      at_limit_s = (count_q == ZERO_VAL);
      wrap_val_s = MAX_VAL;
      step_val_s = count_q - ONE_VAL;
    end
  end

  // Next-state selection with priority clr > load > en > hold; tc defaults low
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = ZERO_VAL;
      ovf_d   = 1'b0;
    end else if (load) begin
      // en and dir are ignored on a load cycle; ovf survives a load
      count_d = load_val;
    end else if (en) begin
      if (at_limit_s) begin
        tc_d  = 1'b1;
        ovf_d = 1'b1;
        if (SAT == MODE_SAT) begin
          count_d = count_q;
        end else begin
          count_d = wrap_val_s;
        end
      end else begin
        count_d = step_val_s;
      end
    end else begin
      count_d = count_q;
    end
  end

  // State flops with asynchronous active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= ZERO_VAL;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/multi_channel_counter.sv
// Shared counter resource: NUM_CH independent counter channels on one clock
// and one reset. This level only slices and concatenates the packed buses.
module multi_channel_counter
  import multi_channel_counter_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned NUM_CH = DEFAULT_NUM_CH,
  parameter int unsigned SAT    = MODE_WRAP
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       dir,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*WIDTH-1:0] load_val,
  input  logic [NUM_CH-1:0]       clr,
  output logic [NUM_CH*WIDTH-1:0] count,
  output logic [NUM_CH-1:0]       tc,
  output logic [NUM_CH-1:0]       ovf
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    counter_channel #(
      .WIDTH (WIDTH),
      .SAT   (SAT)
    ) u_channel (
      .clk      (clk),
      .reset    (reset),
      .en       (en[i]),
      .dir      (dir[i]),
      .load     (load[i]),
      .load_val (load_val[i*WIDTH +: WIDTH]),
      .clr      (clr[i]),
      .count    (count[i*WIDTH +: WIDTH]),
      .tc       (tc[i]),
      .ovf      (ovf[i])
    );
  end

endmodule

// File: tb/tb_multi_channel_counter.sv
// Self-checking bench: one wrapping and one saturating instance driven by the
// same stimulus, checked against an arithmetic reference model.
module tb_multi_channel_counter;

  localparam int W   = 8;
  localparam int NCH = 3;
  localparam int MAXV = (1 << W) - 1;

  logic             clk;
  logic             reset;
  logic [NCH-1:0]   en;
  logic [NCH-1:0]   dir;
  logic [NCH-1:0]   load;
  logic [NCH*W-1:0] load_val;
  logic [NCH-1:0]   clr;

  logic [NCH*W-1:0] count_w, count_s;
  logic [NCH-1:0]   tc_w, tc_s, ovf_w, ovf_s;

  int n_vec = 0;
  int n_bad = 0;

  // model state: index 0 = wrap instance, 1 = saturate instance
  int m_cnt [2][NCH];
  bit m_tc  [2][NCH];
  bit m_ovf [2][NCH];

  multi_channel_counter #(.WIDTH(W), .NUM_CH(NCH), .SAT(0)) dut_wrap (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load),
    .load_val(load_val), .clr(clr), .count(count_w), .tc(tc_w), .ovf(ovf_w));

  multi_channel_counter #(.WIDTH(W), .NUM_CH(NCH), .SAT(1)) dut_sat (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load),
    .load_val(load_val), .clr(clr), .count(count_s), .tc(tc_s), .ovf(ovf_s));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int dut_cnt(int s, int c);
    return (s == 0) ? int'(count_w[c*W +: W]) : int'(count_s[c*W +: W]);
  endfunction
  function automatic bit dut_tc(int s, int c);
    return (s == 0) ? tc_w[c] : tc_s[c];
  endfunction
  function automatic bit dut_ovf(int s, int c);
    return (s == 0) ? ovf_w[c] : ovf_s[c];
  endfunction

  function automatic void model_zero();
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < NCH; c++) begin
        m_cnt[s][c] = 0; m_tc[s][c] = 0; m_ovf[s][c] = 0;
      end
  endfunction

  // reference: apply the rules for one rising edge using plain integer arithmetic
  function automatic void model_step();
    int nxt;
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < NCH; c++) begin
        if (!reset) begin
          m_cnt[s][c] = 0; m_tc[s][c] = 0; m_ovf[s][c] = 0;
        end else if (clr[c]) begin
          m_cnt[s][c] = 0; m_tc[s][c] = 0; m_ovf[s][c] = 0;
        end else if (load[c]) begin
          m_cnt[s][c] = int'(load_val[c*W +: W]); m_tc[s][c] = 0;
        end else if (en[c]) begin
          nxt = m_cnt[s][c] + (dir[c] ? 1 : -1);
          if (nxt < 0 || nxt > MAXV) begin
            m_tc[s][c] = 1; m_ovf[s][c] = 1;
            if (s == 0) m_cnt[s][c] = (nxt + MAXV + 1) % (MAXV + 1);
          end else begin
            m_cnt[s][c] = nxt; m_tc[s][c] = 0;
          end
        end else begin
          m_tc[s][c] = 0;
        end
      end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; #2;
    reset = 1'b0; en = '1; dir = 3'b101;
    model_zero();
    for (int k = 0; k < 3; k++) begin
      tick();
      for (int s = 0; s < 2; s++)
        for (int c = 0; c < NCH; c++) begin
          n_vec++;
          if (dut_cnt(s, c) !== 0 || dut_tc(s, c) !== 1'b0 || dut_ovf(s, c) !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hold inst%0d ch%0d: got cnt=%h tc=%b ovf=%b expected 00/0/0",
                     s, c, dut_cnt(s, c), dut_tc(s, c), dut_ovf(s, c));
          end
        end
    end
    reset = 1'b1; en = '0;
    for (int k = 0; k < 5; k++) begin
      tick();
      for (int s = 0; s < 2; s++)
        for (int c = 0; c < NCH; c++) begin
          n_vec++;
          if (dut_cnt(s, c) !== 0) begin
            n_bad++;
            $display("FAIL post_reset_idle inst%0d ch%0d: got %h expected 00", s, c, dut_cnt(s, c));
          end
        end
    end
  endtask

  task automatic test_up_wrap();
    int exp_c [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    bit exp_t [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    bit exp_o [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    load = 3'b001; load_val = {8'h00, 8'h00, 8'hFD};
    tick();
    load = 3'b000; en = 3'b001; dir = 3'b001;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_vec++;
      if (dut_cnt(0, 0) !== exp_c[k] || tc_w[0] !== exp_t[k] || ovf_w[0] !== exp_o[k]) begin
        n_bad++;
        $display("FAIL up_wrap step%0d: got cnt=%h tc=%b ovf=%b expected %h/%b/%b",
                 k, dut_cnt(0, 0), tc_w[0], ovf_w[0], exp_c[k], exp_t[k], exp_o[k]);
      end
    end
    en = 3'b000;
  endtask

  task automatic test_down_sat();
    int exp_c [5] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    bit exp_t [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    load = 3'b010; load_val = {8'h00, 8'h02, 8'h00};
    tick();
    load = 3'b000; en = 3'b010; dir = 3'b000;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_vec++;
      if (dut_cnt(1, 1) !== exp_c[k] || tc_s[1] !== exp_t[k] || ovf_s[1] !== exp_t[k]) begin
        n_bad++;
        $display("FAIL down_sat step%0d: got cnt=%h tc=%b ovf=%b expected %h/%b/%b",
                 k, dut_cnt(1, 1), tc_s[1], ovf_s[1], exp_c[k], exp_t[k], exp_t[k]);
      end
    end
    en = 3'b000;
  endtask

  task automatic test_priority();
    load = 3'b100; load_val = {8'h00, 8'h00, 8'h00};
    tick();
    load = 3'b000; en = 3'b100; dir = 3'b000;
    tick();
    en = 3'b000; load = 3'b100; load_val = {8'h10, 8'h00, 8'h00};
    tick();
    n_vec++;
    if (dut_cnt(0, 2) !== 8'h10 || ovf_w[2] !== 1'b1) begin
      n_bad++;
      $display("FAIL load_keeps_ovf: got cnt=%h ovf=%b expected 10/1", dut_cnt(0, 2), ovf_w[2]);
    end
    clr = 3'b100; load = 3'b100; en = 3'b100; dir = 3'b100; load_val = {8'h55, 8'h00, 8'h00};
    tick();
    n_vec++;
    if (dut_cnt(0, 2) !== 8'h00 || ovf_w[2] !== 1'b0 || tc_w[2] !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_priority: got cnt=%h ovf=%b tc=%b expected 00/0/0", dut_cnt(0, 2), ovf_w[2], tc_w[2]);
    end
    clr = 3'b000;
    tick();
    n_vec++;
    if (dut_cnt(0, 2) !== 8'h55) begin
      n_bad++;
      $display("FAIL load_over_en: got %h expected 55", dut_cnt(0, 2));
    end
    load = 3'b000; en = 3'b000;
  endtask

  task automatic test_independence();
    clr = 3'b111;
    tick();
    clr = 3'b000; en = 3'b011; dir = 3'b001;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_vec++;
      if (tc_w[1] !== (k == 0) || tc_w[0] !== 1'b0 || tc_w[2] !== 1'b0) begin
        n_bad++;
        $display("FAIL indep_tc cycle%0d: got tc=%b expected %b", k, tc_w, {1'b0, k == 0, 1'b0});
      end
    end
    n_vec++;
    if (count_w !== {8'h00, 8'hF6, 8'h0A} || ovf_w !== 3'b010) begin
      n_bad++;
      $display("FAIL indep_final: got count=%h ovf=%b expected 00f60a/010", count_w, ovf_w);
    end
    en = 3'b000;
  endtask

  task automatic test_async_reset();
    load = 3'b001; load_val = {8'h00, 8'h00, 8'h37};
    tick();
    load = 3'b000; en = 3'b001; dir = 3'b001;
    n_vec++;
    if (dut_cnt(0, 0) !== 8'h37 || ovf_w[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL async_pre: got cnt=%h ovf1=%b expected 37/1", dut_cnt(0, 0), ovf_w[1]);
    end
    #2;
    reset = 1'b0;
    model_zero();
    #1;
    n_vec++;
    if (count_w !== '0 || ovf_w !== '0 || count_s !== '0 || ovf_s !== '0) begin
      n_bad++;
      $display("FAIL async_clear: got count=%h ovf=%b expected all zero", count_w, ovf_w);
    end
    tick();
    reset = 1'b1;
    tick();
    n_vec++;
    if (dut_cnt(0, 0) !== 8'h01) begin
      n_bad++;
      $display("FAIL async_first_edge: got %h expected 01", dut_cnt(0, 0));
    end
    en = 3'b000;
  endtask

  task automatic test_random();
    int pick;
    for (int k = 0; k < 200; k++) begin
      for (int c = 0; c < NCH; c++) begin
        clr[c]  = ($urandom_range(0, 15) == 0);
        load[c] = ($urandom_range(0, 7) == 0);
        en[c]   = ($urandom_range(0, 3) != 0);
        dir[c]  = $urandom_range(0, 1);
        pick    = $urandom_range(0, 4);
        case (pick)
          0: load_val[c*W +: W] = 8'h00;
          1: load_val[c*W +: W] = 8'h01;
          2: load_val[c*W +: W] = 8'hFE;
          3: load_val[c*W +: W] = 8'hFF;
          default: load_val[c*W +: W] = 8'($urandom);
        endcase
      end
      tick();
      for (int s = 0; s < 2; s++)
        for (int c = 0; c < NCH; c++) begin
          n_vec++;
          if (dut_cnt(s, c) !== m_cnt[s][c] || dut_tc(s, c) !== m_tc[s][c] || dut_ovf(s, c) !== m_ovf[s][c]) begin
            n_bad++;
            $display("FAIL random cyc%0d inst%0d ch%0d: got %h/%b/%b expected %h/%b/%b", k, s, c,
                     dut_cnt(s, c), dut_tc(s, c), dut_ovf(s, c), m_cnt[s][c], m_tc[s][c], m_ovf[s][c]);
          end
        end
    end
    clr = '0; load = '0; en = '0;
  endtask

  initial begin
    reset = 1'b1; en = '0; dir = '0; load = '0; load_val = '0; clr = '0;
    model_zero();
    test_reset();
    test_up_wrap();
    test_down_sat();
    test_priority();
    test_independence();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
